mbist_march_ctrl: RTL and testbench

Memory BIST controller that sits directly upstream of the RA1SHD single-port SRAM (and its fault-injection wrapper) in the test path. It drives the memory's CEN/WEN/A/D/OEN pins with a March C- sequence and reads back Q one cycle later. It reports pass/fail, the first failing address, element and bit mask, and a saturating failure count. The design runs one memory operation per clock and inserts no idle cycles between elements.

---
 rtl/mbist_pkg.sv | 37 +++
 rtl/mbist_cmp.sv | 80 ++++++++
 rtl/mbist_march_ctrl.sv | 149 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and March C- element table for the MBIST controller.
package mbist_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} op_e;

   localparam int unsigned ELEM_W = 3;
   localparam logic [ELEM_W-1:0] LAST_ELEM = 3'd5;

   // Bit e set: element e walks addresses upward / has two ops per address.
   localparam logic [7:0] ELEM_UP      = 8'b0010_0111;
   localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;

   function automatic op_e elem_op(input logic [ELEM_W-1:0] elem, input logic op_idx);
      op_e op;
      op = OP_R0;
      case (elem)
         3'd0:    op = OP_W0;
         3'd1:    op = op_idx ? OP_W1 : OP_R0;
         3'd2:    op = op_idx ? OP_W0 : OP_R1;
         3'd3:    op = op_idx ? OP_W1 : OP_R0;
         3'd4:    op = op_idx ? OP_W0 : OP_R1;
         3'd5:    op = OP_R0;
         default: op = OP_R0;
      endcase
      return op;
   endfunction

   function automatic logic op_is_read(input op_e op);
      return (op == OP_R0) || (op == OP_R1);
   endfunction

   function automatic logic op_data_bit(input op_e op);
      return (op == OP_R1) || (op == OP_W1);
   endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Read-data compare: pipelines the expected word, captures the first miscompare
// and keeps a saturating miscompare count.
module mbist_cmp
   import mbist_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_rd_vld,
   input  logic [DATA_W-1:0] i_exp,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ELEM_W-1:0] i_elem,
   input  logic [DATA_W-1:0] i_q,
   output logic              o_fail,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [ELEM_W-1:0] o_fail_elem,
   output logic [DATA_W-1:0] o_fail_bits,
   output logic [CNT_W-1:0]  o_fail_cnt
);

   logic              r_vld;
   logic [DATA_W-1:0] r_exp;
   logic [ADDR_W-1:0] r_addr;
   logic [ELEM_W-1:0] r_elem;
   logic              r_fail;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [ELEM_W-1:0] r_fail_elem;
   logic [DATA_W-1:0] r_fail_bits;
   logic [CNT_W-1:0]  r_fail_cnt;
   logic [DATA_W-1:0] w_diff;
   logic              w_miss;

   assign w_diff = i_q ^ r_exp;
   assign w_miss = r_vld && (|w_diff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld       <= 1'b0;
         r_exp       <= '0;
         r_addr      <= '0;
         r_elem      <= '0;
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
         r_fail_bits <= '0;
         r_fail_cnt  <= '0;
      end else begin
         r_vld  <= i_rd_vld;
         r_exp  <= i_exp;
         r_addr <= i_addr;
         r_elem <= i_elem;
         if (i_clr) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
            r_fail_cnt  <= '0;
         end else if (w_miss) begin
            if (!r_fail) begin
               r_fail      <= 1'b1;
               r_fail_addr <= r_addr;
               r_fail_elem <= r_elem;
               r_fail_bits <= w_diff;
            end
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
         end
      end
   end

   assign o_fail      = r_fail;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_elem = r_fail_elem;
   assign o_fail_bits = r_fail_bits;
   assign o_fail_cnt  = r_fail_cnt;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences elements/ops/addresses, drives the SRAM
// pins one op per clock and hands reads to the compare pipeline.
module mbist_march_ctrl
   import mbist_pkg::*;
#(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_bits,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic              CEN,
   output logic              WEN,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   output logic              OEN,
   input  logic [DATA_W-1:0] Q
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_e            r_state, w_nxt_state;
   logic [ELEM_W-1:0] r_elem, w_nxt_elem;
   logic              r_op, w_nxt_op;
   logic [ADDR_W-1:0] r_addr, w_nxt_addr;
   logic              r_cen, r_wen, r_busy, r_done;
   logic [ADDR_W-1:0] r_a;
   logic [DATA_W-1:0] r_d;
   logic              w_cen, w_wen, w_busy, w_done;
   logic [DATA_W-1:0] w_d;
   logic              w_start_acc, w_last_op, w_last_addr;
   op_e               w_cur_op, w_nxt_opc;

   // Next-state, sequencing and pin-drive decode for the op shown next cycle.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_elem  = r_elem;
      w_nxt_op    = r_op;
      w_nxt_addr  = r_addr;
      w_start_acc = 1'b0;
      w_cur_op    = elem_op(r_elem, r_op);
      w_last_op   = !ELEM_TWO_OPS[r_elem] || r_op;
      w_last_addr = ELEM_UP[r_elem] ? (r_addr == ADDR_MAX) : (r_addr == '0);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_nxt_state = RUN;
               w_nxt_elem  = '0;
               w_nxt_op    = 1'b0;
               w_nxt_addr  = '0;
            end
         end
         RUN: begin
            if (!w_last_op) begin
               w_nxt_op = 1'b1;
            end else begin
               w_nxt_op = 1'b0;
               if (!w_last_addr) begin
                  w_nxt_addr = ELEM_UP[r_elem] ? r_addr + ADDR_W'(1) : r_addr - ADDR_W'(1);
               end else if (r_elem == LAST_ELEM) begin
                  w_nxt_state = DRAIN;
               end else begin
                  w_nxt_elem = r_elem + ELEM_W'(1);
                  w_nxt_addr = ELEM_UP[w_nxt_elem] ? '0 : ADDR_MAX;
               end
            end
         end
         DRAIN:   w_nxt_state = DONE;
         DONE:    w_nxt_state = IDLE;
         default: w_nxt_state = IDLE;
      endcase

      w_nxt_opc = elem_op(w_nxt_elem, w_nxt_op);
      w_cen     = 1'b1;
      w_wen     = 1'b1;
      w_d       = '0;
      if (w_nxt_state == RUN) begin
         w_cen = 1'b0;
         w_wen = op_is_read(w_nxt_opc);
         w_d   = op_is_read(w_nxt_opc) ? '0 : {DATA_W{op_data_bit(w_nxt_opc)}};
      end
      w_busy = (w_nxt_state == RUN) || (w_nxt_state == DRAIN);
      w_done = (w_nxt_state == DONE) || (r_done && !w_start_acc);
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= IDLE;
         r_elem  <= '0;
         r_op    <= 1'b0;
         r_addr  <= '0;
         r_cen   <= 1'b1;
         r_wen   <= 1'b1;
         r_a     <= '0;
         r_d     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_elem  <= w_nxt_elem;
         r_op    <= w_nxt_op;
         r_addr  <= w_nxt_addr;
         r_cen   <= w_cen;
         r_wen   <= w_wen;
         r_a     <= w_cen ? '0 : w_nxt_addr;
         r_d     <= w_d;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   mbist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_cmp (
      .clk         (CLK),
      .rst_n       (RSTN),
      .i_clr       (w_start_acc),
      .i_rd_vld    ((r_state == RUN) && op_is_read(w_cur_op)),
      .i_exp       ({DATA_W{op_data_bit(w_cur_op)}}),
      .i_addr      (r_addr),
      .i_elem      (r_elem),
      .i_q         (Q),
      .o_fail      (fail),
      .o_fail_addr (fail_addr),
      .o_fail_elem (fail_elem),
      .o_fail_bits (fail_bits),
      .o_fail_cnt  (fail_cnt)
   );

   assign CEN  = r_cen;
   assign WEN  = r_wen;
   assign A    = r_a;
   assign D    = r_d;
   assign OEN  = 1'b0;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench: SRAM model with stuck-at faults, March C- reference model,
// pin-sequence monitor and result checks over directed and random runs.
module tb_mbist_march_ctrl;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int N  = 1 << AW;
   localparam int RUN_CYC = 10 * N + 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          CLK = 1'b0;
   logic          RSTN, start;
   logic          busy, done, fail, CEN, WEN, OEN;
   logic [AW-1:0] fail_addr, A;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_bits, D, Q;
   logic [CW-1:0] fail_cnt;

   always #5 CLK = ~CLK;

   mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
      .CLK(CLK), .RSTN(RSTN), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_bits(fail_bits),
      .fail_cnt(fail_cnt), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .OEN(OEN), .Q(Q)
   );

   // SRAM model: reads return stored data forced by per-address stuck-at masks.
   logic [DW-1:0] mem [N];
   logic [DW-1:0] sa0 [N];
   logic [DW-1:0] sa1 [N];
   logic [DW-1:0] q_r;
   assign Q = q_r;
   always @(posedge CLK) begin
      if (!CEN) begin
         if (!WEN) mem[A] <= D;
         else      q_r <= (mem[A] & ~sa0[A]) | sa1[A];
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] a;
      logic          we;
      logic [DW-1:0] d;
   } op_t;

   op_t           exp_q[$];
   logic          exp_fail;
   logic [AW-1:0] exp_addr;
   logic [2:0]    exp_elem;
   logic [DW-1:0] exp_bits;
   int            exp_cnt;

   // March C- table: op codes 0=r0 1=r1 2=w0 3=w1.
   int nops [6] = '{1, 2, 2, 2, 2, 1};
   bit up   [6] = '{1, 1, 1, 0, 0, 1};
   int ops  [6][2] = '{'{2, 0}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, 0}};

   task automatic build_model();
      logic [DW-1:0] m [N];
      logic [DW-1:0] v, got;
      int a, op;
      exp_q.delete();
      exp_fail = 1'b0; exp_addr = '0; exp_elem = '0; exp_bits = '0; exp_cnt = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            a = up[e] ? i : N - 1 - i;
            for (int k = 0; k < nops[e]; k++) begin
               op = ops[e][k];
               v  = (op % 2 == 1) ? '1 : '0;
               if (op >= 2) begin
                  m[a] = v;
                  exp_q.push_back('{a: AW'(a), we: 1'b1, d: v});
               end else begin
                  got = (m[a] & ~sa0[a]) | sa1[a];
                  exp_q.push_back('{a: AW'(a), we: 1'b0, d: '0});
                  if (got != v) begin
                     if (!exp_fail) begin
                        exp_fail = 1'b1; exp_addr = AW'(a); exp_elem = 3'(e); exp_bits = got ^ v;
                     end
                     if (exp_cnt < CNT_MAX) exp_cnt++;
                  end
               end
            end
         end
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < N; i++) begin
         sa0[i] = '0;
         sa1[i] = '0;
      end
   endtask

   task automatic run_test(input string tag, input bit stray, input int abort_at);
      int  cyc, seq_err, idle_busy, stray_cyc;
      bit  got_done;
      op_t o;
      build_model();
      seq_err = 0; idle_busy = 0; got_done = 0;
      stray_cyc = stray ? int'($urandom_range(2, 10 * N - 2)) : -1;
      @(posedge CLK); #1;
      chk({tag, "_cen_before"}, CEN, 1'b1);
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      cyc = 1;
      chk({tag, "_busy_rise"}, busy, 1'b1);
      chk({tag, "_done_clr"}, done, 1'b0);
      forever begin
         if (done) begin got_done = 1; break; end
         if (!CEN) begin
            if (!busy || exp_q.size() == 0) seq_err++;
            else begin
               o = exp_q.pop_front();
               if (A !== o.a || WEN !== !o.we || D !== o.d) seq_err++;
            end
         end else if (busy) idle_busy++;
         if (abort_at != 0 && cyc == abort_at) begin
            #2 RSTN = 1'b0;
            #1;
            chk({tag, "_rst_ctl"}, {busy, done, fail, CEN, WEN, OEN}, 6'b000110);
            chk({tag, "_rst_a"}, A, 0);
            chk({tag, "_rst_cnt"}, fail_cnt, 0);
            chk({tag, "_rst_seq"}, seq_err, 0);
            @(negedge CLK);
            RSTN = 1'b1;
            return;
         end
         start = (cyc == stray_cyc);
         if (cyc > RUN_CYC + 20) break;
         @(posedge CLK); #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, got_done, 1'b1);
      chk({tag, "_cycles"}, cyc, RUN_CYC);
      chk({tag, "_busy_fall"}, busy, 1'b0);
      chk({tag, "_cen_after"}, CEN, 1'b1);
      chk({tag, "_seq_err"}, seq_err, 0);
      chk({tag, "_ops_left"}, exp_q.size(), 0);
      chk({tag, "_drain_cyc"}, idle_busy, 1);
      chk({tag, "_fail"}, fail, exp_fail);
      chk({tag, "_fail_addr"}, fail_addr, exp_addr);
      chk({tag, "_fail_elem"}, fail_elem, exp_elem);
      chk({tag, "_fail_bits"}, fail_bits, exp_bits);
      chk({tag, "_fail_cnt"}, fail_cnt, exp_cnt);
      // start during the DONE cycle must be ignored
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk({tag, "_start_in_done"}, {busy, done, CEN}, 3'b011);
      @(posedge CLK); #1;
      chk({tag, "_idle_hold"}, {busy, done, CEN}, 3'b011);
   endtask

   initial begin
      int a, b;
      RSTN = 1'b0;
      start = 1'b0;
      q_r = '0;
      clear_faults();
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_ctl", {busy, done, fail, CEN, WEN, OEN}, 6'b000110);
      chk("reset_addr", {fail_addr, A}, 0);
      chk("reset_data", {fail_bits, D}, 0);
      chk("reset_elem_cnt", {fail_elem, fail_cnt}, 0);
      @(negedge CLK);
      RSTN = 1'b1;

      run_test("clean", 1'b0, 0);
      chk("clean_cnt_zero", fail_cnt, 0);

      clear_faults();
      sa0[8'h66][27] = 1'b1;
      run_test("sa0", 1'b1, 0);
      chk("sa0_const", {fail, fail_elem, fail_addr, fail_cnt}, {1'b1, 3'd2, 8'h66, 8'd2});
      chk("sa0_bits_const", fail_bits, 32'h0800_0000);

      clear_faults();
      sa1[0][0] = 1'b1;
      run_test("sa1", 1'b0, 0);
      chk("sa1_const", {fail, fail_elem, fail_addr, fail_cnt}, {1'b1, 3'd1, 8'h00, 8'd3});
      chk("sa1_bits_const", fail_bits, 32'h1);

      clear_faults();
      run_test("rst", 1'b0, 3 * N + 1 + int'($urandom_range(0, 2 * N - 1)));
      run_test("after_rst", 1'b0, 0);

      for (int r = 0; r < 3; r++) begin
         clear_faults();
         for (int f = 0; f < 1 + r; f++) begin
            a = int'($urandom_range(0, N - 1));
            b = int'($urandom_range(0, DW - 1));
            if ($urandom_range(0, 1) == 1) sa0[a][b] = 1'b1;
            else                           sa1[a][b] = 1'b1;
         end
         run_test($sformatf("rnd%0d", r), 1'b1, 0);
      end

      clear_faults();
      b = int'($urandom_range(0, DW - 1));
      for (int i = 0; i < N; i++) sa1[i][b] = 1'b1;
      run_test("sat", 1'b0, 0);
      chk("sat_cnt_const", fail_cnt, CNT_MAX);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
